// File: rtl/top_module_uart.sv
// rtl/top_module_uart.sv - 8N1 UART loopback: shared baud tick, TX FSM, RX FSM
//
// Ports:
//   clk         : system clock, all logic on the rising edge
//   reset       : synchronous, active-high reset
//   tx_start    : transmit request, a rising edge starts one frame
//   data_in     : byte to transmit, sampled when the frame is accepted
//   baud_select : 00=2400, 01=4800, 10=9600, 11=19200 baud
//   data_out    : last byte received with a valid stop bit
module top_module_uart #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    input  logic [1:0] baud_select,
    output logic [7:0] data_out
);

    // Rounded divisors: round(CLK_FREQ / (OVERSAMPLE * baud))
    localparam int N0 = (CLK_FREQ + OVERSAMPLE * 2400 / 2)  / (OVERSAMPLE * 2400);
    localparam int N1 = (CLK_FREQ + OVERSAMPLE * 4800 / 2)  / (OVERSAMPLE * 4800);
    localparam int N2 = (CLK_FREQ + OVERSAMPLE * 9600 / 2)  / (OVERSAMPLE * 9600);
    localparam int N3 = (CLK_FREQ + OVERSAMPLE * 19200 / 2) / (OVERSAMPLE * 19200);
    localparam int CW = $clog2(N0 + 1);
    localparam logic [CW-1:0] C_LAST0 = CW'(N0 - 1);
    localparam logic [CW-1:0] C_LAST1 = CW'(N1 - 1);
    localparam logic [CW-1:0] C_LAST2 = CW'(N2 - 1);
    localparam logic [CW-1:0] C_LAST3 = CW'(N3 - 1);

    localparam int TW = $clog2(OVERSAMPLE + 1);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] C_TX_OS  = TW'(OVERSAMPLE);
    localparam logic [TW-1:0] C_TX_ONE = TW'(1);
    // The RX start is seen one tick into the start bit, so mid-bit is 7 ticks later
    localparam logic [SW-1:0] C_RX_MID  = SW'(OVERSAMPLE / 2 - 2);
    localparam logic [SW-1:0] C_RX_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] C_RX_ONE  = SW'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [CW-1:0] w_tick_last;
    logic [CW-1:0] r_tick_cnt;
    logic          r_tick;

    state_t        r_tx_state;
    logic [TW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_idx;
    logic [7:0]    r_tx_shift;
    logic          r_line;
    logic          r_start_q;
    logic          w_start;

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_rx_state;
    logic [SW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_idx;
    logic [7:0]    r_rx_shift;

    always_comb begin
        w_tick_last = C_LAST0;
        case (baud_select)
            2'b00:   w_tick_last = C_LAST0;
            2'b01:   w_tick_last = C_LAST1;
            2'b10:   w_tick_last = C_LAST2;
            default: w_tick_last = C_LAST3;
        endcase
    end

    // >= rather than == so a switch to a shorter divisor wraps at once
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else if (r_tick_cnt >= w_tick_last) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b1;
        end else begin
            r_tick_cnt <= r_tick_cnt + CW'(1);
            r_tick     <= 1'b0;
        end
    end

    assign w_start = tx_start & ~r_start_q;

    // r_tx_cnt counts ticks within the current bit, 1..OVERSAMPLE; the line
    // only changes on a tick so every bit lasts exactly OVERSAMPLE ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_line     <= 1'b1;
            r_start_q  <= 1'b0;
        end else begin
            r_start_q <= tx_start;
            case (r_tx_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_tx_shift <= data_in;
                        r_tx_cnt   <= '0;
                        r_tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_tick) begin
                        if (r_tx_cnt == C_TX_OS) begin
                            r_line     <= r_tx_shift[0];
                            r_tx_cnt   <= C_TX_ONE;
                            r_tx_idx   <= '0;
                            r_tx_state <= S_DATA;
                        end else begin
                            r_line   <= 1'b0;
                            r_tx_cnt <= r_tx_cnt + C_TX_ONE;
                        end
                    end
                end
                S_DATA: begin
                    if (r_tick) begin
                        if (r_tx_cnt == C_TX_OS) begin
                            r_tx_cnt <= C_TX_ONE;
                            if (r_tx_idx == 3'd7) begin
                                r_line     <= 1'b1;
                                r_tx_state <= S_STOP;
                            end else begin
                                r_line     <= r_tx_shift[1];
                                r_tx_shift <= r_tx_shift >> 1;
                                r_tx_idx   <= r_tx_idx + 3'd1;
                            end
                        end else begin
                            r_tx_cnt <= r_tx_cnt + C_TX_ONE;
                        end
                    end
                end
                S_STOP: begin
                    if (r_tick) begin
                        if (r_tx_cnt == C_TX_OS) begin
                            r_tx_cnt   <= '0;
                            r_tx_state <= S_IDLE;
                        end else begin
                            r_tx_cnt <= r_tx_cnt + C_TX_ONE;
                        end
                    end
                end
                default: r_tx_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            data_out   <= 8'h00;
        end else begin
            r_sync1 <= r_line;
            r_sync2 <= r_sync1;
            case (r_rx_state)
                S_IDLE: begin
                    if (r_tick && !r_sync2) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_tick) begin
                        if (r_rx_cnt == C_RX_MID) begin
                            r_rx_cnt   <= '0;
                            r_rx_idx   <= '0;
                            r_rx_state <= r_sync2 ? S_IDLE : S_DATA;
                        end else begin
                            r_rx_cnt <= r_rx_cnt + C_RX_ONE;
                        end
                    end
                end
                S_DATA: begin
                    if (r_tick) begin
                        if (r_rx_cnt == C_RX_LAST) begin
                            r_rx_cnt   <= '0;
                            r_rx_shift <= {r_sync2, r_rx_shift[7:1]};
                            if (r_rx_idx == 3'd7) begin
                                r_rx_state <= S_STOP;
                            end else begin
                                r_rx_idx <= r_rx_idx + 3'd1;
                            end
                        end else begin
                            r_rx_cnt <= r_rx_cnt + C_RX_ONE;
                        end
                    end
                end
                S_STOP: begin
                    if (r_tick) begin
                        if (r_rx_cnt == C_RX_LAST) begin
                            // A low stop bit is a framing error: keep the old byte
                            if (r_sync2) begin
                                data_out <= r_rx_shift;
                            end
                            r_rx_cnt   <= '0;
                            r_rx_state <= S_IDLE;
                        end else begin
                            r_rx_cnt <= r_rx_cnt + C_RX_ONE;
                        end
                    end
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_top_module_uart.sv
// tb/tb_top_module_uart.sv - directed loopback bench for top_module_uart
module tb_top_module_uart;

    // Reduced clock so every baud rate fits a short run; divisors 52/26/13/7
    localparam int CLK_FREQ = 2_000_000;
    localparam int N_00 = 52;
    localparam int N_01 = 26;
    localparam int N_10 = 13;
    localparam int N_11 = 7;

    logic       clk;
    logic       reset;
    logic       tx_start;
    logic [7:0] data_in;
    logic [1:0] baud_select;
    logic [7:0] data_out;

    int         checks;
    int         errors;
    int         cyc;
    int         t0;
    logic [7:0] prev_out;

    top_module_uart #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_start    (tx_start),
        .data_in     (data_in),
        .baud_select (baud_select),
        .data_out    (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [7:0] b, input logic [1:0] sel);
        prev_out    = data_out;
        data_in     = b;
        baud_select = sel;
        tx_start    = 1'b1;
        t0          = cyc;
    endtask

    // Wait for data_out to change, then check value and latency window
    task automatic wait_out(input string tag, input logic [7:0] exp, input int n);
        int c;
        c = cyc - t0;
        while (data_out === prev_out && c < 160 * n) begin
            step(1);
            c = cyc - t0;
        end
        check_eq({tag, "_val"}, {24'h0, data_out}, {24'h0, exp});
        check_eq({tag, "_early"}, (c >= 152 * n + 1) ? 32'd1 : 32'd0, 32'd1);
        check_eq({tag, "_late"}, (c <= 153 * n + 4) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic frame(input string tag, input logic [7:0] b, input logic [1:0] sel, input int n);
        start_frame(b, sel);
        wait_out(tag, b, n);
        tx_start = 1'b0;
        step(32 * n);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        reset       = 1'b1;
        tx_start    = 1'b0;
        data_in     = 8'h00;
        baud_select = 2'b11;
        step(4);
        reset = 1'b0;
        step(2);
        check_eq("rst_data_out", {24'h0, data_out}, 32'h0);
        check_eq("rst_line", {31'h0, dut.r_line}, 32'h1);

        // First frame with a second start pulse while busy (must be ignored)
        start_frame(8'hAA, 2'b11);
        step(12);
        tx_start = 1'b0;
        data_in  = 8'h55;
        step(2);
        tx_start = 1'b1;
        wait_out("aa", 8'hAA, N_11);
        tx_start = 1'b0;
        step(2 * 160 * N_11);
        check_eq("aa_no_second", {24'h0, data_out}, 32'hAA);

        frame("b00_5a", 8'h5A, 2'b00, N_00);
        frame("b10_3c", 8'h3C, 2'b10, N_10);
        frame("b01_e7", 8'hE7, 2'b01, N_01);
        frame("b2b_01", 8'h01, 2'b11, N_11);
        frame("b2b_ff", 8'hFF, 2'b11, N_11);

        // Reset in the middle of the data bits of a C3 frame
        start_frame(8'hC3, 2'b11);
        step(4 * 16 * N_11);
        tx_start = 1'b0;
        reset    = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        check_eq("midrst_data_out", {24'h0, data_out}, 32'h0);
        check_eq("midrst_line", {31'h0, dut.r_line}, 32'h1);
        step(2 * 160 * N_11);
        check_eq("midrst_no_update", {24'h0, data_out}, 32'h0);
        frame("after_rst_81", 8'h81, 2'b11, N_11);

        // tx_start held high for three frames, data_in changed after the edge
        start_frame(8'h96, 2'b11);
        step(5);
        data_in = 8'h11;
        wait_out("hold_96", 8'h96, N_11);
        step(2 * 160 * N_11);
        check_eq("hold_one_frame", {24'h0, data_out}, 32'h96);
        tx_start = 1'b0;
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
